round_robin_arbiter_8: RTL and testbench
========================================

Name: round_robin_arbiter_8

Overview:
- Eight-requester round-robin arbiter with registered one-hot grant. It shares one downstream resource, such as a shared gate, bus driver or memory port, between up to eight circuit blocks.
- Request inputs take a per-bit inversion mask, the same semantics as the gate-library bubble mask, so active-low requesters connect directly.
- It sits between the requesting blocks and the shared-resource enable in the processor top level.

Parameters:
- BubblesMask, 0: 8-bit mask; bit i=1 inverts Request[i] before arbitration (active-low requester).
- MaxHoldCycles, 0: maximum consecutive cycles one holder keeps the grant while others wait. 0 = unlimited. Legal range 0..255.

Ports:
- GlobalClock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-high reset.
- ClockEnable  in  1  tick qualifier. State advances only on edges where it is 1.
- Request  in  8  raw request lines, bit i = requester i.
- Grant  out  8  registered one-hot grant, all-zero when idle.
- GrantValid  out  1  1 when any Grant bit is set.
- GrantIndex  out  3  binary index of the granted requester, 0 when idle.

Behaviour:
- Effective request: req_eff[i] = Request[i] XOR BubblesMask[i]. It is combinational and never registered.
- Reset (async, active-high):
  - Grant=0, GrantValid=0, GrantIndex=0.
  - Priority pointer ptr=0, so requester 0 has highest priority first.
  - Hold counter=0, state=IDLE.
  - Outputs clear immediately on Reset assertion, without waiting for a clock edge.
- All state updates occur on rising GlobalClock edges with ClockEnable=1. With ClockEnable=0, everything holds.
- Pick function: the first i with req_eff[i]=1, searching ptr, ptr+1, ... ptr+7, modulo 8 (wrap-around).
- FSM states: IDLE, GRANTED.
  - IDLE, no req_eff: stay in IDLE.
  - IDLE, any req_eff: register Grant=onehot(pick), GrantIndex=pick, counter=1, go to GRANTED. Latency is one enabled edge from request to grant.
  - GRANTED, holder's req_eff still 1 and (MaxHoldCycles=0 or counter<MaxHoldCycles or no other req_eff): hold the grant. The counter increments and saturates at 255.
  - GRANTED, holder's req_eff dropped: set ptr=holder+1 (mod 8).
    - If another request is pending, grant pick(new ptr) on the same edge, with no idle gap, and set counter=1.
    - Otherwise Grant=0 and go to IDLE.
  - GRANTED, holder still requesting, MaxHoldCycles≠0, counter==MaxHoldCycles and another req_eff pending: forced rotation. Set ptr=holder+1 and grant pick(new ptr). The old holder is excluded this edge even if it is the only other candidate found by wrap.
- GrantValid = |Grant. GrantIndex is registered together with Grant and is always consistent with it.
- Simultaneous requests: only the pick winner is granted. The others wait; their requests are not latched and must stay asserted.
- A requester that drops and re-raises its request while not granted loses nothing; its priority depends only on ptr.
- Grant is never multi-hot. Grant is never given to a requester whose req_eff was 0 at the deciding edge.
- Reset mid-grant aborts the grant immediately. After reset release, arbitration restarts from ptr=0.

Decomposition:
- Shared package:
  - state encoding: IDLE=0, GRANTED=1;
  - NUM_REQ=8;
  - IDX_W=3;
  - CNT_W=8.
- One sub-module: rr_priority_picker.
  - Purely combinational.
  - Inputs: req_eff[7:0], ptr[2:0], exclude_en, exclude_idx[2:0].
  - Outputs: found, idx[2:0].
  - Implemented as rotate-right by ptr, find-first-set, add ptr back mod 8.
- The top holds the FSM, ptr, counter and output registers.

Test Plan:
- Reset then Request=8'b0000_0101, ClockEnable=1 -> after 1 edge Grant=8'b0000_0001, GrantIndex=0. Drop bit0 -> next edge Grant=8'b0000_0100, GrantIndex=2, no idle cycle.
- Wrap-around: holder=6 drops while Request=8'b0000_0011 -> next grant is index 0, then index 1 after 0 drops. Index 7 is never granted.
- BubblesMask=8'hFF, Request=8'hFF -> Grant stays 0 (idle). Request=8'hF7 -> Grant=8'b0000_1000.
- MaxHoldCycles=3, requesters 1 and 4 held high continuously -> grant alternates 1,4,1,4 every 3 enabled cycles.
- ClockEnable=0 for 5 edges with requests pending -> outputs frozen. The first enabled edge performs the grant.
- Assert Reset asynchronously mid-cycle while Grant=8'b0010_0000 -> Grant=0, GrantValid=0 before the next edge. After release with Request=8'h22, the grant goes to index 1 (ptr=0).

Source files
------------

// File: rtl/round_robin_arbiter_8_pkg.sv
// Shared types and sizes for the eight-way round-robin arbiter.
// Imported by the interface, the picker and the top.
package round_robin_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;
  localparam int CNT_W   = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    GRANTED = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(
    input logic [IDX_W-1:0] i
  );
    return NUM_REQ'(1) << i;
  endfunction

endpackage

// File: rtl/round_robin_arbiter_8_if.sv
// Request/grant bundle between the requesting blocks and the arbiter.
// The arbiter takes the slave view; requesters take the master view.
interface round_robin_arbiter_8_if;
  import round_robin_arbiter_8_pkg::*;

  logic               ClockEnable;
  logic [NUM_REQ-1:0] Request;
  logic [NUM_REQ-1:0] Grant;
  logic               GrantValid;
  logic [IDX_W-1:0]   GrantIndex;

  modport master (
    output ClockEnable,
    output Request,
    input  Grant,
    input  GrantValid,
    input  GrantIndex
  );

  modport slave (
    input  ClockEnable,
    input  Request,
    output Grant,
    output GrantValid,
    output GrantIndex
  );

endinterface

// File: rtl/round_robin_arbiter_8_picker.sv
// Combinational round-robin pick: rotate by ptr, find first set,
// then add ptr back so the result is an absolute requester index.
module rr_priority_picker
  import round_robin_arbiter_8_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_eff,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               exclude_en,
  input  logic [IDX_W-1:0]   exclude_idx,
  output logic               found,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0]   cand;
  logic [NUM_REQ-1:0]   rot;
  logic [2*NUM_REQ-1:0] dbl;
  logic [IDX_W-1:0]     off;

  always_comb begin
    cand = req_eff;
    if (exclude_en) begin
      cand[exclude_idx] = 1'b0;
    end
    dbl   = {cand, cand} >> ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = IDX_W'(j);
      end
    end
    idx = off + ptr;
  end

endmodule

// File: rtl/round_robin_arbiter_8.sv
// Eight-requester round-robin arbiter with registered one-hot grant,
// per-bit request inversion and an optional maximum hold time.
module round_robin_arbiter_8
  import round_robin_arbiter_8_pkg::*;
#(
  parameter logic [NUM_REQ-1:0] BubblesMask   = '0,
  parameter int                 MaxHoldCycles = 0
) (
  input logic                    GlobalClock,
  input logic                    Reset,
  round_robin_arbiter_8_if.slave bus
);

  localparam logic [CNT_W-1:0] MAX_HOLD = CNT_W'(MaxHoldCycles);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic [NUM_REQ-1:0] req_eff;
  logic [IDX_W-1:0]   pick_ptr;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_found;
  logic               granted;
  logic               others;
  logic               hold_ok;

  assign req_eff  = bus.Request ^ BubblesMask;
  assign granted  = (state_q == GRANTED);
  assign pick_ptr = granted ? idx_q + IDX_W'(1) : ptr_q;
  assign others   = |(req_eff & ~onehot(idx_q));
  assign hold_ok  = req_eff[idx_q] &&
                    (MAX_HOLD == '0 ||
                     cnt_q < MAX_HOLD ||
                     !others);

  // While granted, the holder is always excluded from the re-pick
  rr_priority_picker u_picker (
    .req_eff     (req_eff),
    .ptr         (pick_ptr),
    .exclude_en  (granted),
    .exclude_idx (idx_q),
    .found       (pick_found),
    .idx         (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = GRANTED;
          grant_d = onehot(pick_idx);
          idx_d   = pick_idx;
          cnt_d   = CNT_W'(1);
        end
      end
      GRANTED: begin
        if (hold_ok) begin
          if (cnt_q != CNT_SAT) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          ptr_d = pick_ptr;
          if (pick_found) begin
            grant_d = onehot(pick_idx);
            idx_d   = pick_idx;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = IDLE;
            grant_d = '0;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge GlobalClock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      idx_q   <= '0;
    end else if (bus.ClockEnable) begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.Grant      = grant_q;
  assign bus.GrantValid = |grant_q;
  assign bus.GrantIndex = idx_q;

endmodule

// File: tb/tb_round_robin_arbiter_8.sv
// Scoreboard bench: three arbiter variants share one stimulus stream
// and are compared against a queue-fed behavioural model.
module tb_round_robin_arbiter_8;
  import round_robin_arbiter_8_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce  = 1'b0;
  logic [7:0] req = 8'h00;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  round_robin_arbiter_8_if b0 ();
  round_robin_arbiter_8_if b1 ();
  round_robin_arbiter_8_if b2 ();

  assign b0.ClockEnable = ce;
  assign b1.ClockEnable = ce;
  assign b2.ClockEnable = ce;
  assign b0.Request     = req;
  assign b1.Request     = req;
  assign b2.Request     = req;

  round_robin_arbiter_8 #(
    .BubblesMask(8'h00), .MaxHoldCycles(0)
  ) d0 (.GlobalClock(clk), .Reset(rst), .bus(b0));

  round_robin_arbiter_8 #(
    .BubblesMask(8'hFF), .MaxHoldCycles(0)
  ) d1 (.GlobalClock(clk), .Reset(rst), .bus(b1));

  round_robin_arbiter_8 #(
    .BubblesMask(8'h00), .MaxHoldCycles(3)
  ) d2 (.GlobalClock(clk), .Reset(rst), .bus(b2));

  wire [11:0] a0 = {b0.Grant, b0.GrantValid, b0.GrantIndex};
  wire [11:0] a1 = {b1.Grant, b1.GrantValid, b1.GrantIndex};
  wire [11:0] a2 = {b2.Grant, b2.GrantValid, b2.GrantIndex};

  // Reference model: holder = -1 means nobody holds the resource
  logic [7:0] mmask [3];
  int         mmax  [3];
  int         mhold [3];
  int         mptr  [3];
  int         mcnt  [3];

  initial begin
    mmask[0] = 8'h00; mmax[0] = 0;
    mmask[1] = 8'hFF; mmax[1] = 0;
    mmask[2] = 8'h00; mmax[2] = 3;
  end

  function automatic int pick(logic [7:0] eff, int p, int excl);
    for (int o = 0; o < 8; o++) begin
      int i;
      i = (p + o) % 8;
      if (i != excl && eff[i]) return i;
    end
    return -1;
  endfunction

  task automatic mreset();
    for (int k = 0; k < 3; k++) begin
      mhold[k] = -1;
      mptr[k]  = 0;
      mcnt[k]  = 0;
    end
  endtask

  task automatic mstep(int k, logic [7:0] r);
    logic [7:0] eff;
    int w;
    bit others;
    eff = r ^ mmask[k];
    if (mhold[k] < 0) begin
      w = pick(eff, mptr[k], -1);
      if (w >= 0) begin
        mhold[k] = w;
        mcnt[k]  = 1;
      end
    end else begin
      others = 1'b0;
      for (int i = 0; i < 8; i++)
        if (i != mhold[k] && eff[i]) others = 1'b1;
      if (eff[mhold[k]] &&
          (mmax[k] == 0 || mcnt[k] < mmax[k] || !others)) begin
        if (mcnt[k] < 255) mcnt[k] = mcnt[k] + 1;
      end else begin
        mptr[k] = (mhold[k] + 1) % 8;
        w = pick(eff, mptr[k], mhold[k]);
        if (w >= 0) begin
          mhold[k] = w;
          mcnt[k]  = 1;
        end else begin
          mhold[k] = -1;
          mcnt[k]  = 0;
        end
      end
    end
  endtask

  function automatic logic [11:0] expv(int w);
    logic [7:0] g;
    if (w < 0) return 12'h000;
    g = 8'h01 << w;
    return {g, 1'b1, 3'(w)};
  endfunction

  logic [35:0] sbq[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mreset();
    end else begin
      if (ce)
        for (int k = 0; k < 3; k++) mstep(k, req);
      sbq.push_back({expv(mhold[2]), expv(mhold[1]),
                     expv(mhold[0])});
    end
  end

  task automatic chk(string nm, logic [11:0] act,
                     logic [11:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got grant=%h idx=%0d v=%b, want grant=%h idx=%0d v=%b",
               nm, act[11:4], act[2:0], act[3],
               exp[11:4], exp[2:0], exp[3]);
    end
  endtask

  initial begin
    logic [35:0] e;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("sb_d0", a0, e[11:0]);
        chk("sb_d1", a1, e[23:12]);
        chk("sb_d2", a2, e[35:24]);
      end
    end
  end

  task automatic cyc(logic [7:0] r, logic e);
    @(negedge clk);
    req = r;
    ce  = e;
    @(posedge clk);
    #1;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_d0", a0, 12'h000);
    chk("rst_d1", a1, 12'h000);
    chk("rst_d2", a2, 12'h000);
  endtask

  initial begin
    int f, o, w;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("init_d0", a0, 12'h000);
    chk("init_d1", a1, 12'h000);
    chk("init_d2", a2, 12'h000);
    rst = 1'b0;

    cyc(8'h05, 1'b1);
    chk("first", a0, expv(0));
    cyc(8'h04, 1'b1);
    chk("no_gap", a0, expv(2));

    cyc(8'h44, 1'b1);
    cyc(8'h40, 1'b1);
    chk("to6", a0, expv(6));
    cyc(8'h03, 1'b1);
    chk("wrap0", a0, expv(0));
    cyc(8'h02, 1'b1);
    chk("wrap1", a0, expv(1));
    cyc(8'h00, 1'b1);
    chk("idle", a0, 12'h000);

    cyc(8'hFF, 1'b1);
    chk("bub_idle", a1, 12'h000);
    cyc(8'hFF, 1'b1);
    chk("bub_idle2", a1, 12'h000);
    cyc(8'hF7, 1'b1);
    chk("bub_g3", a1, expv(3));

    cyc(8'h00, 1'b1);
    cyc(8'h00, 1'b1);
    cyc(8'h12, 1'b1);
    f = int'(b2.GrantIndex);
    o = (f == 4) ? 1 : 4;
    chk("hold_first", a2, expv(f == 4 ? 4 : 1));
    for (int n = 2; n <= 12; n++) begin
      cyc(8'h12, 1'b1);
      w = (((n - 1) / 3) % 2 == 0) ? f : o;
      chk("hold_rot", a2, expv(w));
    end

    cyc(8'h00, 1'b1);
    for (int n = 0; n < 5; n++) begin
      cyc(8'h10, 1'b0);
      chk("ce_frozen", a0, 12'h000);
    end
    cyc(8'h10, 1'b1);
    chk("ce_grant", a0, expv(4));
    cyc(8'h20, 1'b1);
    chk("pre_rst", a0, expv(5));

    async_reset();
    @(negedge clk);
    rst = 1'b0;
    req = 8'h22;
    ce  = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst", a0, expv(1));

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(149) == 0) begin
        async_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      if ($urandom_range(1) == 0)
        cyc(8'($urandom), $urandom_range(9) != 0);
      else
        cyc(8'($urandom & $urandom & $urandom),
            $urandom_range(9) != 0);
    end

    cyc(8'h00, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
